// File: rtl/main_memory_server.sv
// Backing-memory responder: one load/store at a time, fixed access latency, backdoor preload port.
// Define MAIN_MEM_PERF_EN to add saturating load/store/error counters.
module main_memory_server #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned BASE_ADDR = 0,
  localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,
  input  logic            bd_we,
  input  logic [AW-1:0]   bd_addr,
  input  logic [XLEN-1:0] bd_wdata
`ifdef MAIN_MEM_PERF_EN
  ,
  output logic [31:0]     perf_loads,
  output logic [31:0]     perf_stores,
  output logic [31:0]     perf_errors
`endif
);

  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   mem [MEM_WORDS];

  logic              op_q, err_q;
  logic [1:0]        size_q, lane_q;
  logic [AW-1:0]     idx_q;
  logic [XLEN-1:0]   wdata_q;

  logic [XLEN-1:0]   req_off;
  logic              req_err;
  logic              cur_op, cur_err;
  logic [1:0]        cur_size, cur_lane;
  logic [AW-1:0]     cur_idx;
  logic [XLEN-1:0]   cur_rdata;

  function automatic logic [XLEN-1:0] lane_read(input logic [XLEN-1:0] word,
                                                input logic [1:0] size, input logic [1:0] lane);
    logic [XLEN-1:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      2'd0:    return XLEN'(shifted[7:0]);
      2'd1:    return XLEN'(shifted[15:0]);
      default: return shifted;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] old, input logic [XLEN-1:0] wdata,
                                                 input logic [1:0] size, input logic [1:0] lane);
    logic [XLEN-1:0] mask;
    case (size)
      2'd0:    mask = XLEN'(8'hFF);
      2'd1:    mask = XLEN'(16'hFFFF);
      default: mask = '1;
    endcase
    mask = mask << {lane, 3'b000};
    return (old & ~mask) | ((wdata << {lane, 3'b000}) & mask);
  endfunction

  assign req_off = req_addr - XLEN'(BASE_ADDR);
  assign req_err = (req_size == 2'd3)
                || (req_size == 2'd1 && req_off[0])
                || (req_size == 2'd2 && req_off[1:0] != 2'b00)
                || (req_addr < XLEN'(BASE_ADDR))
                || (req_off[XLEN-1:AW+2] != '0);

  // In IDLE the response is built from the live request (LATENCY == 1), otherwise from the latched one.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    cur_op    = op_q;
    cur_err   = err_q;
    cur_size  = size_q;
    cur_lane  = lane_q;
    cur_idx   = idx_q;
    if (state == IDLE) begin
      cur_op   = req_op;
      cur_err  = req_err;
      cur_size = req_size;
      cur_lane = req_off[1:0];
      cur_idx  = req_off[AW+1:2];
    end
    cur_rdata = (cur_op || cur_err) ? '0 : lane_read(mem[cur_idx], cur_size, cur_lane);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      op_q      <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          op_q      <= req_op;
          err_q     <= req_err;
          size_q    <= req_size;
          lane_q    <= req_off[1:0];
          idx_q     <= req_off[AW+1:2];
          wdata_q   <= req_wdata;
          req_ready <= 1'b0;
          if (LATENCY <= 1) begin
            state     <= RESPOND;
            rsp_valid <= 1'b1;
            rsp_rdata <= cur_rdata;
            rsp_error <= cur_err;
          end else begin
            state <= BUSY;
            cnt   <= CW'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            cnt       <= '0;
            state     <= RESPOND;
            rsp_valid <= 1'b1;
            rsp_rdata <= cur_rdata;
            rsp_error <= cur_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESPOND: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; only the state that gates writes is.
  always_ff @(posedge clk) begin
    if (state == IDLE && bd_we)
      mem[bd_addr] <= bd_wdata;
    else if (state == RESPOND && op_q && !err_q)
      mem[idx_q] <= lane_merge(mem[idx_q], wdata_q, size_q, lane_q);
  end

`ifdef MAIN_MEM_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errors <= '0;
    end else if (state == RESPOND) begin
      if (err_q) begin
        if (perf_errors != '1) perf_errors <= perf_errors + 32'd1;
      end else if (op_q) begin
        if (perf_stores != '1) perf_stores <= perf_stores + 32'd1;
      end else begin
        if (perf_loads != '1) perf_loads <= perf_loads + 32'd1;
      end
    end
  end
`endif

  bd_idle_only: assert property (@(posedge clk) disable iff (!reset_n) bd_we |-> state == IDLE)
    else $error("backdoor write issued outside IDLE was ignored");

endmodule
